// File: rtl/aes_uart_stream_ctrl.sv
// aes_uart_stream_ctrl: packs UART RX bytes into 128-bit blocks and runs each block
// through external encrypt/decrypt engines, then streams the result back over UART.
// Optional feature macro: RX_FLUSH_EN (idle timeout flushes a partial block, zero padded).
module aes_uart_stream_ctrl #(
   parameter int unsigned NUM_BLOCKS     = 4,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [1:0]   mode_i,
   input  logic [7:0]   rx_data_i,
   input  logic         rx_valid_i,
   output logic [7:0]   tx_data_o,
   output logic         tx_start_o,
   input  logic         tx_done_i,
   output logic         enc_start_o,
   output logic [127:0] enc_data_o,
   input  logic [127:0] enc_result_i,
   input  logic         enc_done_i,
   output logic         dec_start_o,
   output logic [127:0] dec_data_o,
   input  logic [127:0] dec_result_i,
   input  logic         dec_done_i,
   output logic         busy_o,
   output logic         frame_done_o,
   output logic [15:0]  blk_cnt_o,
   output logic         err_overrun_o
);

   localparam int unsigned BLK_W     = 128;
   localparam int unsigned BYTE_W    = 8;
   localparam int unsigned BYTES     = BLK_W / BYTE_W;
   localparam int unsigned CNT_W     = $clog2(BYTES);
   localparam int unsigned BLK_CNT_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

   typedef enum logic [2:0] {
      S_COLLECT = 3'd0,
      S_ENC     = 3'd1,
      S_DEC     = 3'd2,
      S_TX      = 3'd3,
      S_NEXT    = 3'd4
   } state_e;

   state_e               state_q, state_d;
   logic [CNT_W-1:0]     byte_cnt_q, byte_cnt_d;
   logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [CNT_W-1:0]     tx_cnt_nxt;
   logic [BLK_CNT_W-1:0] blk_cnt_q, blk_cnt_d;
   logic [BLK_W-1:0]     block_q, block_d;
   logic [BLK_W-1:0]     res_q, res_d;
   logic [BLK_W-1:0]     enc_data_q, enc_data_d;
   logic [BLK_W-1:0]     dec_data_q, dec_data_d;
   logic                 enc_start_q, enc_start_d;
   logic                 dec_start_q, dec_start_d;
   logic                 enc_wait_q, enc_wait_d;
   logic                 dec_wait_q, dec_wait_d;
   logic [BYTE_W-1:0]    tx_data_q, tx_data_d;
   logic                 tx_start_q, tx_start_d;
   logic                 tx_busy_q, tx_busy_d;
   logic                 tx_entry_q, tx_entry_d;
   logic                 cipher_q, cipher_d;
   logic                 mode_dec_q, mode_dec_d;
   logic                 mode_rt_q, mode_rt_d;
   logic                 busy_q, busy_d;
   logic                 frame_done_q, frame_done_d;
   logic                 err_q, err_d;
   logic                 blk_full;

`ifdef RX_FLUSH_EN
   localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [IDLE_W-1:0]    idle_q, idle_d;
`else
   logic [31:0]          unused_timeout;
   assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= S_COLLECT;
         byte_cnt_q   <= '0;
         tx_cnt_q     <= '0;
         blk_cnt_q    <= '0;
         block_q      <= '0;
         res_q        <= '0;
         enc_data_q   <= '0;
         dec_data_q   <= '0;
         enc_start_q  <= 1'b0;
         dec_start_q  <= 1'b0;
         enc_wait_q   <= 1'b0;
         dec_wait_q   <= 1'b0;
         tx_data_q    <= '0;
         tx_start_q   <= 1'b0;
         tx_busy_q    <= 1'b0;
         tx_entry_q   <= 1'b0;
         cipher_q     <= 1'b0;
         mode_dec_q   <= 1'b0;
         mode_rt_q    <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         err_q        <= 1'b0;
`ifdef RX_FLUSH_EN
         idle_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         tx_cnt_q     <= tx_cnt_d;
         blk_cnt_q    <= blk_cnt_d;
         block_q      <= block_d;
         res_q        <= res_d;
         enc_data_q   <= enc_data_d;
         dec_data_q   <= dec_data_d;
         enc_start_q  <= enc_start_d;
         dec_start_q  <= dec_start_d;
         enc_wait_q   <= enc_wait_d;
         dec_wait_q   <= dec_wait_d;
         tx_data_q    <= tx_data_d;
         tx_start_q   <= tx_start_d;
         tx_busy_q    <= tx_busy_d;
         tx_entry_q   <= tx_entry_d;
         cipher_q     <= cipher_d;
         mode_dec_q   <= mode_dec_d;
         mode_rt_q    <= mode_rt_d;
         busy_q       <= busy_d;
         frame_done_q <= frame_done_d;
         err_q        <= err_d;
`ifdef RX_FLUSH_EN
         idle_q       <= idle_d;
`endif
      end
   end

   // Next-state, datapath and registered-output logic
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      tx_cnt_d     = tx_cnt_q;
      tx_cnt_nxt   = tx_cnt_q + CNT_W'(1);
      blk_cnt_d    = blk_cnt_q;
      block_d      = block_q;
      res_d        = res_q;
      enc_data_d   = enc_data_q;
      dec_data_d   = dec_data_q;
      enc_start_d  = 1'b0;
      dec_start_d  = 1'b0;
      enc_wait_d   = enc_wait_q;
      dec_wait_d   = dec_wait_q;
      tx_data_d    = tx_data_q;
      tx_start_d   = 1'b0;
      tx_busy_d    = tx_busy_q;
      tx_entry_d   = 1'b0;
      cipher_d     = cipher_q;
      mode_dec_d   = mode_dec_q;
      mode_rt_d    = mode_rt_q;
      frame_done_d = 1'b0;
      err_d        = err_q | (rx_valid_i && (state_q != S_COLLECT));
      blk_full     = 1'b0;
`ifdef RX_FLUSH_EN
      idle_d       = '0;
`endif

      case (state_q)
         S_COLLECT: begin
            if (rx_valid_i) begin
               // byte 0 clears the block so a flushed block is zero padded
               if (byte_cnt_q == '0) begin
                  block_d = BLK_W'(rx_data_i);
               end else begin
                  block_d[{byte_cnt_q, 3'b000} +: BYTE_W] = rx_data_i;
               end
               if ((byte_cnt_q == '0) && (blk_cnt_q == '0)) begin
                  mode_dec_d = (mode_i == 2'b01);
                  mode_rt_d  = (mode_i == 2'b10);
               end
               byte_cnt_d = byte_cnt_q + CNT_W'(1);
               blk_full   = (byte_cnt_q == CNT_W'(BYTES - 1));
            end
`ifdef RX_FLUSH_EN
            else if (byte_cnt_q != '0) begin
               if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
                  blk_full   = 1'b1;
                  byte_cnt_d = '0;
               end else begin
                  idle_d = idle_q + IDLE_W'(1);
               end
            end
`endif
            if (blk_full) begin
               if (mode_dec_d) begin
                  state_d     = S_DEC;
                  dec_start_d = 1'b1;
                  dec_wait_d  = 1'b1;
                  dec_data_d  = block_d;
               end else begin
                  state_d     = S_ENC;
                  enc_start_d = 1'b1;
                  enc_wait_d  = 1'b1;
                  enc_data_d  = block_d;
               end
            end
         end
         S_ENC: begin
            if (enc_wait_q && enc_done_i) begin
               res_d      = enc_result_i;
               enc_wait_d = 1'b0;
               cipher_d   = mode_rt_q;
               tx_cnt_d   = '0;
               tx_entry_d = 1'b1;
               state_d    = S_TX;
            end
         end
         S_DEC: begin
            if (dec_wait_q && dec_done_i) begin
               res_d      = dec_result_i;
               dec_wait_d = 1'b0;
               cipher_d   = 1'b0;
               tx_cnt_d   = '0;
               tx_entry_d = 1'b1;
               state_d    = S_TX;
            end
         end
         S_TX: begin
            if (tx_entry_q) begin
               tx_start_d = 1'b1;
               tx_busy_d  = 1'b1;
               tx_data_d  = res_q[BYTE_W-1:0];
            end else if (tx_busy_q && tx_done_i) begin
               tx_busy_d = 1'b0;
               if (tx_cnt_q == CNT_W'(BYTES - 1)) begin
                  tx_cnt_d = '0;
                  if (cipher_q) begin
                     // round trip: the ciphertext just sent goes back through decrypt
                     cipher_d    = 1'b0;
                     state_d     = S_DEC;
                     dec_start_d = 1'b1;
                     dec_wait_d  = 1'b1;
                     dec_data_d  = res_q;
                  end else begin
                     state_d = S_NEXT;
                  end
               end else begin
                  tx_cnt_d   = tx_cnt_nxt;
                  tx_start_d = 1'b1;
                  tx_busy_d  = 1'b1;
                  tx_data_d  = res_q[{tx_cnt_nxt, 3'b000} +: BYTE_W];
               end
            end
         end
         S_NEXT: begin
            state_d = S_COLLECT;
            if (blk_cnt_q == BLK_CNT_W'(NUM_BLOCKS - 1)) begin
               blk_cnt_d    = '0;
               frame_done_d = 1'b1;
            end else begin
               blk_cnt_d = blk_cnt_q + BLK_CNT_W'(1);
            end
         end
         default: state_d = S_COLLECT;
      endcase

      busy_d = (state_d != S_COLLECT) || (byte_cnt_d != '0);
   end

   assign tx_data_o     = tx_data_q;
   assign tx_start_o    = tx_start_q;
   assign enc_start_o   = enc_start_q;
   assign enc_data_o    = enc_data_q;
   assign dec_start_o   = dec_start_q;
   assign dec_data_o    = dec_data_q;
   assign busy_o        = busy_q;
   assign frame_done_o  = frame_done_q;
   assign blk_cnt_o     = 16'(blk_cnt_q);
   assign err_overrun_o = err_q;

endmodule
